// File: rtl/data_mem_resp_if.sv
// Memory-stage request/response bundle between the
// pipeline initiator and the multi-cycle data memory.
interface data_mem_resp_if;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        err;

    modport master (
        output Addr, DataIn, Rd, Wr,
        input  DataOut, Done, Stall, err
    );

    modport slave (
        input  Addr, DataIn, Rd, Wr,
        output DataOut, Done, Stall, err
    );
endinterface

// File: rtl/data_mem_resp.sv
// Fixed-latency data memory responder: accepts one-cycle
// Rd/Wr pulses, stalls for LAT-1 cycles, then pulses Done.
module data_mem_resp #(
    parameter int ADDR_W = 8,
    parameter int LAT    = 4
) (
    input logic             clk,
    input logic             rst,
    data_mem_resp_if.slave  bus
);

    if (LAT < 2 || LAT > 15) begin : g_bad_lat
        $error("data_mem_resp: LAT must be in 2..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic                op_wr;
    logic [ADDR_W-1:0]   idx;
    logic [15:0]         wdata;
    logic [15:0]         dout;
    logic                done;
    logic                stall;
    logic                err;
    logic [15:0]         mem [2**ADDR_W];

    logic req;
    logic accept;
    logic bad;
    logic fire;
    logic unused_addr;

    assign req    = bus.Rd | bus.Wr;
    assign accept = (state != WAIT) && (bus.Rd ^ bus.Wr)
                    && !bus.Addr[0];
    assign bad    = (bus.Rd & bus.Wr)
                    | (req & bus.Addr[0])
                    | (req & (state == WAIT));
    assign fire   = (state == WAIT) && (cnt == 4'd0);

    // Upper address bits are ignored so addresses wrap.
    assign unused_addr = ^bus.Addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            op_wr <= 1'b0;
            idx   <= '0;
            wdata <= 16'h0000;
            dout  <= 16'h0000;
            done  <= 1'b0;
            stall <= 1'b0;
            err   <= 1'b0;
        end else begin
            err  <= bad;
            done <= 1'b0;
            unique case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        state <= WAIT;
                        cnt   <= 4'(LAT - 2);
                        op_wr <= bus.Wr;
                        idx   <= bus.Addr[ADDR_W:1];
                        wdata <= bus.DataIn;
                        stall <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                        stall <= 1'b0;
                        done  <= 1'b1;
                        if (!op_wr) begin
                            dout <= mem[idx];
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    stall <= 1'b0;
                end
            endcase
        end
    end

    // Array is deliberately unreset; an aborted write never
    // commits because reset forces state out of WAIT.
    always_ff @(posedge clk) begin
        if (fire && op_wr) begin
            mem[idx] <= wdata;
        end
    end

    assign bus.DataOut = dout;
    assign bus.Done    = done;
    assign bus.Stall   = stall;
    assign bus.err     = err;

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: expected DataOut per
// Done is queued at issue, checked by a separate monitor.
module tb_data_mem_resp;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    logic [15:0] exp_q [$];

    data_mem_resp_if bus ();

    data_mem_resp #(.ADDR_W(8), .LAT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [15:0] act,
                         input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every Done pops one expected DataOut.
    always @(negedge clk) begin
        if (!rst && bus.Done === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL done_unexpected: got %h expected none",
                         bus.DataOut);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if (bus.DataOut !== e) begin
                    n_bad++;
                    $display("FAIL done_data: got %h expected %h",
                             bus.DataOut, e);
                end
            end
        end
    end

    // Drive a one-cycle request from a negedge; returns at the
    // negedge after the sampling edge (first cycle of service).
    task automatic issue(input logic rd, input logic wr,
                         input logic [15:0] addr,
                         input logic [15:0] data,
                         input bit push,
                         input logic [15:0] exp);
        bus.Rd     = rd;
        bus.Wr     = wr;
        bus.Addr   = addr;
        bus.DataIn = data;
        if (push) exp_q.push_back(exp);
        @(negedge clk);
        bus.Rd = 1'b0;
        bus.Wr = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            if (bus.Done === 1'b1) break;
            @(negedge clk);
        end
        check("done_timeout", {15'd0, bus.Done}, 16'd1);
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        rst        = 1'b1;
        bus.Rd     = 1'b0;
        bus.Wr     = 1'b0;
        bus.Addr   = 16'h0000;
        bus.DataIn = 16'h0000;

        #1;
        check("rst_dout", bus.DataOut, 16'h0000);
        check("rst_flags", {13'd0, bus.Done, bus.Stall, bus.err},
              16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Write BEEF @0x10: DataOut still reset value at Done.
        issue(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b1, 16'h0000);
        wait_done();
        @(negedge clk);

        // Read latency: Stall 3 cycles, Done in cycle 4.
        issue(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF);
        check("lat_stall1", {15'd0, bus.Stall}, 16'd1);
        @(negedge clk);
        check("lat_stall2", {15'd0, bus.Stall}, 16'd1);
        @(negedge clk);
        check("lat_stall3", {15'd0, bus.Stall}, 16'd1);
        check("lat_nodone3", {15'd0, bus.Done}, 16'd0);
        @(negedge clk);
        check("lat_done4", {15'd0, bus.Done}, 16'd1);
        check("lat_stall4", {15'd0, bus.Stall}, 16'd0);
        @(negedge clk);
        check("lat_idle", {14'd0, bus.Done, bus.Stall}, 16'd0);

        // Back-to-back with wrap: 0x0202 aliases 0x0002.
        issue(1'b0, 1'b1, 16'h0002, 16'h1234, 1'b1, 16'hBEEF);
        wait_done();
        issue(1'b1, 1'b0, 16'h0202, 16'h0000, 1'b1, 16'h1234);
        check("b2b_stall", {15'd0, bus.Stall}, 16'd1);
        repeat (3) @(negedge clk);
        check("b2b_done", {15'd0, bus.Done}, 16'd1);
        @(negedge clk);

        // Rd and Wr together.
        issue(1'b1, 1'b1, 16'h0010, 16'h0000, 1'b0, 16'h0000);
        check("both_err", {15'd0, bus.err}, 16'd1);
        check("both_stall", {15'd0, bus.Stall}, 16'd0);
        @(negedge clk);
        check("both_err_clr", {15'd0, bus.err}, 16'd0);

        // Misaligned address.
        issue(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'h0000);
        check("odd_err", {15'd0, bus.err}, 16'd1);
        check("odd_stall", {15'd0, bus.Stall}, 16'd0);
        @(negedge clk);
        check("odd_err_clr", {15'd0, bus.err}, 16'd0);

        // Request during WAIT is dropped; original completes.
        issue(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'hBEEF);
        issue(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'h0000);
        check("wait_err", {15'd0, bus.err}, 16'd1);
        check("wait_stall", {15'd0, bus.Stall}, 16'd1);
        @(negedge clk);
        check("wait_err_clr", {15'd0, bus.err}, 16'd0);
        @(negedge clk);
        check("wait_done4", {15'd0, bus.Done}, 16'd1);
        @(negedge clk);

        // Reset mid-write: old contents survive.
        issue(1'b0, 1'b1, 16'h0020, 16'h5555, 1'b1, 16'hBEEF);
        wait_done();
        @(negedge clk);
        issue(1'b0, 1'b1, 16'h0020, 16'hAAAA, 1'b0, 16'h0000);
        #2 rst = 1'b1;
        #1;
        check("arst_dout", bus.DataOut, 16'h0000);
        check("arst_flags", {13'd0, bus.Done, bus.Stall, bus.err},
              16'h0000);
        @(negedge clk);
        rst = 1'b0;
        issue(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h5555);
        wait_done();
        @(negedge clk);

        // Writes leave DataOut at the last read value.
        issue(1'b0, 1'b1, 16'h0030, 16'h00FF, 1'b1, 16'h5555);
        wait_done();
        issue(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 16'h00FF);
        wait_done();
        issue(1'b0, 1'b1, 16'h0030, 16'h7777, 1'b1, 16'h00FF);
        wait_done();
        @(negedge clk);
        check("wr_keep_dout", bus.DataOut, 16'h00FF);
        issue(1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, 16'h7777);
        wait_done();

        repeat (3) @(negedge clk);
        check("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
